weight_stream_loader: RTL and testbench

- Upstream feeder for the vector multiplier's weight scratchpad.
- Accepts a serial stream of weights over a valid/ready handshake and packs WEIGHT_ROWS weights into one column buffer.
- Presents the full column as a parallel unpacked array with its own valid/ack handshake, repeating for WEIGHT_COLS columns per job.
- The multiplier consumes one complete column at a time and never sees a partially filled column.

---
 rtl/weight_stream_loader.sv | 241 ++++++++++++++++++++++++
 tb/tb_weight_stream_loader.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_stream_loader.sv
// weight_stream_loader: packs a serial weight stream into full columns.
// Optional ping-pong column banks when WEIGHT_LOADER_DBUF_EN is defined.
module weight_stream_loader #(
  parameter int WEIGHT_WIDTH = 5,
  parameter int WEIGHT_ROWS  = 96,
  parameter int WEIGHT_COLS  = 3,
  localparam int ROW_IDX_W =
    (WEIGHT_ROWS > 1) ? $clog2(WEIGHT_ROWS) : 1,
  localparam int COL_IDX_W =
    (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    start,
  input  logic                    w_valid,
  output logic                    w_ready,
  input  logic [WEIGHT_WIDTH-1:0] w_data,
  output logic [WEIGHT_WIDTH-1:0] weights_out [0:WEIGHT_ROWS-1],
  output logic                    col_valid,
  input  logic                    col_ack,
  output logic [COL_IDX_W-1:0]    col_idx,
  output logic                    busy,
  output logic                    done
);

  localparam logic [ROW_IDX_W-1:0] LAST_ROW =
    ROW_IDX_W'(WEIGHT_ROWS - 1);
  localparam logic [COL_IDX_W-1:0] LAST_COL =
    COL_IDX_W'(WEIGHT_COLS - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    PRESENT
  } state_t;

  state_t               state_q, state_d;
  logic [ROW_IDX_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
  logic                 done_q, done_d;
  logic                 beat;

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign col_idx = col_idx_q;

`ifdef WEIGHT_LOADER_DBUF_EN

  // FILL means columns remain to be streamed; PRESENT means
  // every column is loaded and only acks are outstanding.
  logic [WEIGHT_WIDTH-1:0] bank_q [0:1][0:WEIGHT_ROWS-1];
  logic [WEIGHT_WIDTH-1:0] bank_d [0:1][0:WEIGHT_ROWS-1];
  logic [COL_IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [1:0]              full_q, full_d;
  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;

  assign weights_out = bank_q[rd_bank_q];

  // Fill and present run concurrently on opposite banks.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    col_idx_d  = col_idx_q;
    fill_idx_d = fill_idx_q;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    done_d     = 1'b0;
    w_ready    = 1'b0;
    col_valid  = full_q[rd_bank_q];
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = FILL;
          wr_ptr_d   = '0;
          col_idx_d  = '0;
          fill_idx_d = '0;
          full_d     = '0;
          wr_bank_d  = 1'b0;
          rd_bank_d  = 1'b0;
        end
      end
      FILL: begin
        w_ready = !full_q[wr_bank_q];
      end
      PRESENT: begin
        w_ready = 1'b0;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    beat = w_valid && w_ready;
    if (beat) begin
      if (wr_ptr_q == LAST_ROW) begin
        wr_ptr_d          = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        fill_idx_d        = fill_idx_q + 1'b1;
        if (fill_idx_q == LAST_COL) begin
          state_d = PRESENT;
        end
      end else begin
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
    end
    if (col_valid && col_ack) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
      if (col_idx_q == LAST_COL) begin
        state_d   = IDLE;
        col_idx_d = '0;
        done_d    = 1'b1;
      end else begin
        col_idx_d = col_idx_q + 1'b1;
      end
    end
  end

  // Accepted beat lands in the bank being filled.
  always_comb begin
    bank_d = bank_q;
    if (beat) begin
      bank_d[wr_bank_q][wr_ptr_q] = w_data;
    end
  end

  // Control and bank registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      col_idx_q  <= '0;
      fill_idx_q <= '0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      done_q     <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < WEIGHT_ROWS; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      col_idx_q  <= col_idx_d;
      fill_idx_q <= fill_idx_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      done_q     <= done_d;
      bank_q     <= bank_d;
    end
  end

`else

  logic [WEIGHT_WIDTH-1:0] buf_q [0:WEIGHT_ROWS-1];
  logic [WEIGHT_WIDTH-1:0] buf_d [0:WEIGHT_ROWS-1];

  assign weights_out = buf_q;

  // Single bank: fill and present strictly alternate.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    col_idx_d = col_idx_q;
    done_d    = 1'b0;
    w_ready   = 1'b0;
    col_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = FILL;
          wr_ptr_d  = '0;
          col_idx_d = '0;
        end
      end
      FILL: begin
        w_ready = 1'b1;
        if (w_valid) begin
          if (wr_ptr_q == LAST_ROW) begin
            state_d  = PRESENT;
            wr_ptr_d = '0;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
          end
        end
      end
      PRESENT: begin
        col_valid = 1'b1;
        if (col_ack) begin
          if (col_idx_q == LAST_COL) begin
            state_d   = IDLE;
            col_idx_d = '0;
            done_d    = 1'b1;
          end else begin
            state_d   = FILL;
            col_idx_d = col_idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    beat = w_valid && w_ready;
  end

  // Accepted beat lands at the write pointer.
  always_comb begin
    buf_d = buf_q;
    if (beat) begin
      buf_d[wr_ptr_q] = w_data;
    end
  end

  // Control and column buffer registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      col_idx_q <= '0;
      done_q    <= 1'b0;
      for (int i = 0; i < WEIGHT_ROWS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      col_idx_q <= col_idx_d;
      done_q    <= done_d;
      buf_q     <= buf_d;
    end
  end

`endif

endmodule

// File: tb/tb_weight_stream_loader.sv
// tb_weight_stream_loader: scoreboard bench for weight_stream_loader.
// Build with WEIGHT_LOADER_DBUF_EN to exercise the ping-pong variant.
module tb_weight_stream_loader;

  localparam int WW = 5;
  localparam int WR = 96;
  localparam int WC = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          w_valid;
  logic          w_ready;
  logic [WW-1:0] w_data;
  logic [WW-1:0] weights_out [0:WR-1];
  logic          col_valid;
  logic          col_ack;
  logic [1:0]    col_idx;
  logic          busy;
  logic          done;

  int errs     = 0;
  int checks   = 0;
  int done_cnt = 0;

  logic [WW-1:0] exp_q [$];

  always #5 clk = ~clk;

  weight_stream_loader #(
    .WEIGHT_WIDTH (WW),
    .WEIGHT_ROWS  (WR),
    .WEIGHT_COLS  (WC)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_data      (w_data),
    .weights_out (weights_out),
    .col_valid   (col_valid),
    .col_ack     (col_ack),
    .col_idx     (col_idx),
    .busy        (busy),
    .done        (done)
  );

  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic compare_col(input int col);
    logic [WW-1:0] e;
    check("col_valid", col_valid, 1);
    check("col_idx", col_idx, col);
    for (int k = 0; k < WR; k++) begin
      if (exp_q.size() == 0) begin
        check("sb_empty", 0, 1);
        break;
      end
      e = exp_q.pop_front();
      check($sformatf("c%0d_w%0d", col, k), weights_out[k], e);
    end
  endtask

  // Drives n beats starting at the current negedge.
  task automatic stream(input int n, input int col,
                        input bit bubble, input bit noise,
                        input bit rnd, output int cyc);
    int sent = 0;
    int bad  = 0;
    logic [WW-1:0] d;
    cyc = 0;
    while (sent < n && cyc < 4 * WR) begin
      w_valid = !(bubble && cyc[0]);
      d = rnd ? WW'($urandom) : WW'(col * WR + sent);
      w_data = w_valid ? d : WW'($urandom);
      if (noise) begin
        col_ack = cyc[2];
        start   = cyc[3];
      end
      if (col_valid || !busy || col_idx != 2'(col)) bad++;
      if (w_valid && w_ready) begin
        exp_q.push_back(d);
        sent++;
      end
      cyc++;
      @(negedge clk);
    end
    w_valid = 1'b0;
    col_ack = 1'b0;
    start   = 1'b0;
    check("fill_status", bad, 0);
    check("beats_sent", sent, n);
  endtask

  // Presents a column, holds off the ack, then acks it.
  task automatic present(input int col, input int hold,
                         input bit last);
    int bad = 0;
    logic [WW-1:0] s0, s1;
    compare_col(col);
    s0 = weights_out[0];
    s1 = weights_out[WR-1];
    for (int h = 0; h < hold; h++) begin
      w_valid = 1'b1;
      w_data  = WW'($urandom);
      if (w_ready || !col_valid || col_idx != 2'(col) ||
          weights_out[0] != s0 || weights_out[WR-1] != s1)
        bad++;
      @(negedge clk);
    end
    w_valid = 1'b0;
    check("hold_stable", bad, 0);
    col_ack = 1'b1;
    @(negedge clk);
    col_ack = 1'b0;
    check("cv_drop", col_valid, 0);
    if (last) begin
      check("done_hi", done, 1);
      check("idle_busy", busy, 0);
      check("idle_idx", col_idx, 0);
      @(negedge clk);
      check("done_lo", done, 0);
    end else begin
      check("done_mid", done, 0);
      check("next_idx", col_idx, col + 1);
      check("next_ready", w_ready, 1);
    end
  endtask

  task automatic full_col(input int col, input int hold,
                          input bit bubble, input bit noise,
                          input bit rnd);
    int cyc;
    stream(WR, col, bubble, noise, rnd, cyc);
    check("fill_cycles", cyc, bubble ? 2 * WR - 1 : WR);
    present(col, hold, col == WC - 1);
  endtask

`ifdef WEIGHT_LOADER_DBUF_EN
  task automatic dbuf_job();
    pulse_start();
    fork
      begin
        int sent = 0;
        int cyc  = 0;
        int bad  = 0;
        logic [WW-1:0] d;
        while (sent < WC * WR && cyc < 8 * WR) begin
          w_valid = 1'b1;
          d = WW'($urandom);
          w_data = d;
          if (w_ready) begin
            exp_q.push_back(d);
            sent++;
          end else begin
            bad++;
          end
          cyc++;
          @(negedge clk);
        end
        w_valid = 1'b0;
        check("db_cycles", cyc, WC * WR);
        check("db_stalls", bad, 0);
        check("db_ready_end", w_ready, 0);
      end
      begin
        for (int c = 0; c < WC; c++) begin
          int t = 0;
          while (!col_valid && t < 8 * WR) begin
            @(negedge clk);
            t++;
          end
          repeat (10) @(negedge clk);
          compare_col(c);
          col_ack = 1'b1;
          @(negedge clk);
          col_ack = 1'b0;
        end
        check("db_done", done, 1);
      end
    join
    repeat (3) @(negedge clk);
    check("db_done_cnt", done_cnt, 1);
    check("db_idle", busy, 0);
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    reset_n = 1'b0;
    start   = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;
    col_ack = 1'b0;
    #1;
    check("rst_ready", w_ready, 0);
    check("rst_cv", col_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_idx", col_idx, 0);
    check("rst_w0", weights_out[0], 0);
    check("rst_w95", weights_out[WR-1], 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    col_ack = 1'b1;
    w_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_ack_busy", busy, 0);
    check("idle_ack_ready", w_ready, 0);
    check("idle_ack_cv", col_valid, 0);
    col_ack = 1'b0;
    w_valid = 1'b0;
`ifdef WEIGHT_LOADER_DBUF_EN
    dbuf_job();
`else
    pulse_start();
    check("start_busy", busy, 1);
    check("start_ready", w_ready, 1);
    full_col(0, 20, 1'b0, 1'b1, 1'b0);
    full_col(1, 2, 1'b0, 1'b0, 1'b0);
    full_col(2, 2, 1'b0, 1'b0, 1'b0);
    check("done_cnt1", done_cnt, 1);

    pulse_start();
    full_col(0, 2, 1'b1, 1'b0, 1'b1);
    stream(50, 1, 1'b0, 1'b0, 1'b1, cyc);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", w_ready, 0);
    check("mid_rst_cv", col_valid, 0);
    check("mid_rst_idx", col_idx, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_w0", weights_out[0], 0);
    check("mid_rst_w49", weights_out[49], 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle", busy, 0);

    pulse_start();
    full_col(0, 2, 1'b0, 1'b0, 1'b1);
    full_col(1, 2, 1'b0, 1'b0, 1'b1);
    full_col(2, 2, 1'b0, 1'b0, 1'b1);
    check("done_cnt2", done_cnt, 2);
`endif
    check("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
